// File: rtl/act_bit_place_scheduler.sv
// Bit-place scheduler: tags each accepted activation with its popcount, pulls that many
// bit places from the converter (or inserts a zero beat) and emits an ordered, framed stream.
module act_bit_place_scheduler #(
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [7:0]                   InData,
  output logic                         ConvWriteEnable,
  output logic [7:0]                   ConvWriteData,
  input  logic                         ConvWriteReady,
  output logic                         ConvReadEnable,
  input  logic                         ConvReadReady,
  input  logic [2:0]                   ConvReadData,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [2:0]                   OutBitPlace,
  output logic                         OutLast,
  output logic                         OutZero,
  output logic [$clog2(TAG_DEPTH):0]   Outstanding
);

  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_DEPTH);

  typedef struct packed {
    logic [2:0] place;
    logic       last;
    logic       zero;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FETCH, ZERO} drain_t;

  logic [3:0]       tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] tag_wr, tag_rd;
  logic [CNT_W-1:0] tag_count;
  logic             tag_full, tag_empty;
  logic [3:0]       head_tag;
  logic [3:0]       issued_cnt;
  logic             inflight, inflight_last;

  beat_t            buf_mem [2];
  logic             buf_wr, buf_rd;
  logic [1:0]       buf_count;

  drain_t           drain;
  logic             accept, tag_pop, issue, read_last, zero_write;
  logic             out_pop, buf_push, buf_pop, out_dec;
  logic [2:0]       occ_after;
  beat_t            ret_beat, head_beat, buf_wdata;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign tag_full  = (tag_count == DEPTH_C);
  assign tag_empty = (tag_count == '0);
  assign head_tag  = tag_mem[tag_rd];

  assign InReady         = !tag_full && ((InData == 8'h00) || ConvWriteReady);
  assign accept          = InValid && InReady;
  assign ConvWriteEnable = accept && (InData != 8'h00);
  assign ConvWriteData   = InData;

  // Returning read data bypasses the buffer when it is empty, giving read-to-OutValid of one cycle.
  always_comb begin
    ret_beat.place = ConvReadData;
    ret_beat.last  = inflight_last;
    ret_beat.zero  = 1'b0;
    head_beat      = (buf_count != 2'd0) ? buf_mem[buf_rd] : ret_beat;
  end

  assign OutValid    = (buf_count != 2'd0) || inflight;
  assign out_pop     = OutValid && OutReady;
  assign OutBitPlace = OutValid ? head_beat.place : 3'd0;
  assign OutLast     = OutValid && head_beat.last;
  assign OutZero     = OutValid && head_beat.zero;
  assign out_dec     = out_pop && head_beat.last;
  assign occ_after   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, out_pop};

  always_comb begin
    drain      = IDLE;
    issue      = 1'b0;
    zero_write = 1'b0;
    read_last  = ((issued_cnt + 4'd1) == head_tag);
    if (!tag_empty) drain = (head_tag == 4'd0) ? ZERO : FETCH;
    case (drain)
      FETCH:   issue      = ConvReadReady && (occ_after < 3'd2);
      ZERO:    zero_write = !inflight && (occ_after < 3'd2);
      default: ;
    endcase
  end

  assign ConvReadEnable = issue;
  assign tag_pop        = (issue && read_last) || zero_write;

  always_comb begin
    buf_push        = zero_write || (inflight && !((buf_count == 2'd0) && out_pop));
    buf_pop         = out_pop && (buf_count != 2'd0);
    buf_wdata       = ret_beat;
    if (zero_write) begin
      buf_wdata.place = 3'd0;
      buf_wdata.last  = 1'b1;
      buf_wdata.zero  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) tag_mem[tag_wr] <= popcount8(InData);
    if (buf_push) buf_mem[buf_wr] <= buf_wdata;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tag_wr        <= '0;
      tag_rd        <= '0;
      tag_count     <= '0;
      issued_cnt    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_wr        <= 1'b0;
      buf_rd        <= 1'b0;
      buf_count     <= '0;
      Outstanding   <= '0;
    end else begin
      if (accept)  tag_wr <= tag_wr + 1'b1;
      if (tag_pop) tag_rd <= tag_rd + 1'b1;
      tag_count <= tag_count + CNT_W'(accept) - CNT_W'(tag_pop);
      if (issue) issued_cnt <= read_last ? 4'd0 : issued_cnt + 4'd1;
      inflight      <= issue;
      inflight_last <= issue && read_last;
      if (buf_push) buf_wr <= ~buf_wr;
      if (buf_pop)  buf_rd <= ~buf_rd;
      buf_count   <= buf_count + 2'(buf_push) - 2'(buf_pop);
      Outstanding <= Outstanding + CNT_W'(accept) - CNT_W'(out_dec);
    end
  end

endmodule

// File: tb/tb_act_bit_place_scheduler.sv
// Bench for act_bit_place_scheduler: LSB-first converter model, beat scoreboard built from
// each accepted value's set bits, a vector table, directed corner sequences and random traffic.
module tb_act_bit_place_scheduler;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [7:0] InData = 8'h00;
  logic       ConvWriteEnable;
  logic [7:0] ConvWriteData;
  logic       ConvWriteReady = 1'b1;
  logic       ConvReadEnable;
  logic       ConvReadReady;
  logic [2:0] ConvReadData;
  logic       OutValid;
  logic       OutReady = 1'b0;
  logic [2:0] OutBitPlace;
  logic       OutLast;
  logic       OutZero;
  logic [3:0] Outstanding;

  act_bit_place_scheduler #(.TAG_DEPTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .ConvWriteEnable(ConvWriteEnable), .ConvWriteData(ConvWriteData), .ConvWriteReady(ConvWriteReady),
    .ConvReadEnable(ConvReadEnable), .ConvReadReady(ConvReadReady), .ConvReadData(ConvReadData),
    .OutValid(OutValid), .OutReady(OutReady), .OutBitPlace(OutBitPlace),
    .OutLast(OutLast), .OutZero(OutZero), .Outstanding(Outstanding)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] place;
    logic       last;
    logic       zero;
  } exp_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       wr;
    logic       exp_rdy;
    logic       exp_wen;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   exp_out = 0;
  int   re_cnt = 0, we_cnt = 0, pop_cnt = 0, acc_cnt = 0;
  logic pv_hold = 1'b0;
  exp_t pv_beat;
  logic rnd_out = 1'b0;

  // Converter model: each written value becomes its set-bit positions, lowest first.
  logic       conv_stall = 1'b0;
  logic [2:0] bp_q[$];
  int         bp_count = 0;
  logic [2:0] rdata = 3'd0;

  assign ConvReadReady = (bp_count != 0) && !conv_stall;
  assign ConvReadData  = rdata;

  always @(posedge CLK or negedge RSTN) begin : conv_model
    int d;
    if (!RSTN) begin
      bp_q.delete();
      bp_count <= 0;
      rdata    <= 3'd0;
    end else begin
      d = 0;
      if (ConvReadEnable && bp_q.size() > 0) begin
        rdata <= bp_q.pop_front();
        d = d - 1;
      end
      if (ConvWriteEnable)
        for (int i = 0; i < 8; i++)
          if (ConvWriteData[i]) begin
            bp_q.push_back(3'(i));
            d = d + 1;
          end
      bp_count <= bp_count + d;
    end
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  always @(negedge CLK) begin : monitor
    int   hi;
    exp_t e;
    if (!RSTN) begin
      exp_q.delete();
      exp_out = 0;
      pv_hold = 1'b0;
    end else begin
      chk("outstanding", int'(Outstanding), exp_out);
      if (ConvReadEnable) begin
        chk("read_ready_at_issue", int'(ConvReadReady), 1);
        re_cnt++;
      end
      if (ConvWriteEnable) we_cnt++;
      if (pv_hold) begin
        chk("hold_valid", int'(OutValid), 1);
        chk("hold_beat", int'({OutBitPlace, OutLast, OutZero}), int'(pv_beat));
      end
      if (InValid && InReady) begin
        acc_cnt++;
        exp_out++;
        if (InData == 8'h00) begin
          e.place = 3'd0; e.last = 1'b1; e.zero = 1'b1;
          exp_q.push_back(e);
        end else begin
          hi = 0;
          for (int i = 0; i < 8; i++) if (InData[i]) hi = i;
          for (int i = 0; i < 8; i++)
            if (InData[i]) begin
              e.place = 3'(i); e.last = (i == hi); e.zero = 1'b0;
              exp_q.push_back(e);
            end
        end
      end
      if (OutValid && OutReady) begin
        pop_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: got %0d with nothing expected", {OutBitPlace, OutLast, OutZero});
        end else begin
          e = exp_q.pop_front();
          if ({OutBitPlace, OutLast, OutZero} != e) begin
            bad++;
            $display("FAIL beat: got place=%0d last=%0d zero=%0d want place=%0d last=%0d zero=%0d",
                     OutBitPlace, OutLast, OutZero, e.place, e.last, e.zero);
          end
          if (e.last) exp_out--;
        end
      end
      pv_hold = OutValid && !OutReady;
      pv_beat = {OutBitPlace, OutLast, OutZero};
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int a0;
    InValid = 1'b1;
    InData  = v;
    a0 = acc_cnt;
    for (int k = 0; k < 60 && acc_cnt == a0; k++) begin
      if (rnd_out) OutReady = 1'($urandom_range(0, 1));
      step();
    end
    InValid = 1'b0;
    InData  = 8'h00;
    chk("send_accepted", acc_cnt - a0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (exp_q.size() != 0 || exp_out != 0); k++) begin
      OutReady = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    OutReady = 1'b1;
    chk("drain_pending_beats", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t tab[6];
    int   r0, w0, p0, a0;
    tab[0] = '{v: 1'b1, d: 8'h00, wr: 1'b0, exp_rdy: 1'b1, exp_wen: 1'b0};
    tab[1] = '{v: 1'b1, d: 8'h05, wr: 1'b0, exp_rdy: 1'b0, exp_wen: 1'b0};
    tab[2] = '{v: 1'b1, d: 8'h05, wr: 1'b1, exp_rdy: 1'b1, exp_wen: 1'b1};
    tab[3] = '{v: 1'b0, d: 8'h30, wr: 1'b1, exp_rdy: 1'b1, exp_wen: 1'b0};
    tab[4] = '{v: 1'b1, d: 8'h00, wr: 1'b1, exp_rdy: 1'b1, exp_wen: 1'b0};
    tab[5] = '{v: 1'b1, d: 8'h81, wr: 1'b1, exp_rdy: 1'b1, exp_wen: 1'b1};

    // reset values
    repeat (3) step();
    chk("rst_outvalid", int'(OutValid), 0);
    chk("rst_readen", int'(ConvReadEnable), 0);
    chk("rst_outstanding", int'(Outstanding), 0);
    chk("rst_inready", int'(InReady), 1);
    RSTN = 1'b1;
    OutReady = 1'b1;
    repeat (2) step();

    // vector table on the upstream handshake
    for (int i = 0; i < 6; i++) begin
      InValid = tab[i].v; InData = tab[i].d; ConvWriteReady = tab[i].wr;
      #2;
      chk($sformatf("vec%0d_inready", i), int'(InReady), int'(tab[i].exp_rdy));
      chk($sformatf("vec%0d_wen", i), int'(ConvWriteEnable), int'(tab[i].exp_wen));
      chk($sformatf("vec%0d_wdata", i), int'(ConvWriteData), int'(tab[i].d));
      step();
    end
    InValid = 1'b0; InData = 8'h00; ConvWriteReady = 1'b1;
    drain();

    // 1: 0x12 -> (1) then (4,last), two reads
    step();
    InValid = 1'b1; InData = 8'h12; r0 = re_cnt;
    #2 chk("t1_inready", int'(InReady), 1);
    step(); InValid = 1'b0; InData = 8'h00;
    #2 chk("t1_c1_outvalid", int'(OutValid), 0);
    chk("t1_c1_readen", int'(ConvReadEnable), 1);
    chk("t1_c1_outstanding", int'(Outstanding), 1);
    step(); #2;
    chk("t1_c2_outvalid", int'(OutValid), 1);
    chk("t1_c2_beat", int'({OutBitPlace, OutLast, OutZero}), int'({3'd1, 1'b0, 1'b0}));
    step(); #2;
    chk("t1_c3_beat", int'({OutValid, OutBitPlace, OutLast, OutZero}), int'({1'b1, 3'd4, 1'b1, 1'b0}));
    chk("t1_c3_readen", int'(ConvReadEnable), 0);
    step(); #2;
    chk("t1_c4_outvalid", int'(OutValid), 0);
    chk("t1_c4_outstanding", int'(Outstanding), 0);
    chk("t1_read_pulses", re_cnt - r0, 2);

    // 2: zero value bypasses the converter
    step();
    ConvWriteReady = 1'b0; InValid = 1'b1; InData = 8'h00; w0 = we_cnt;
    #2 chk("t2_inready", int'(InReady), 1);
    chk("t2_wen", int'(ConvWriteEnable), 0);
    step(); InValid = 1'b0; ConvWriteReady = 1'b1;
    #2 chk("t2_c1_outvalid", int'(OutValid), 0);
    step(); #2;
    chk("t2_c2_beat", int'({OutValid, OutBitPlace, OutLast, OutZero}), int'({1'b1, 3'd0, 1'b1, 1'b1}));
    step(); #2;
    chk("t2_c3_outvalid", int'(OutValid), 0);
    chk("t2_writes", we_cnt - w0, 0);

    // 3: 0xFF under backpressure, then release
    OutReady = 1'b0;
    step();
    InValid = 1'b1; InData = 8'hFF; r0 = re_cnt;
    step(); InValid = 1'b0; InData = 8'h00;
    repeat (19) step();
    #2;
    chk("t3_stalled_reads", re_cnt - r0, 2);
    chk("t3_head_beat", int'({OutValid, OutBitPlace, OutLast}), int'({1'b1, 3'd0, 1'b0}));
    OutReady = 1'b1; p0 = pop_cnt;
    repeat (8) step();
    #2;
    chk("t3_b2b_pops", pop_cnt - p0, 8);
    chk("t3_total_reads", re_cnt - r0, 8);
    chk("t3_after_outvalid", int'(OutValid), 0);

    // 4: fill the tag FIFO with the converter starved
    step();
    OutReady = 1'b0; conv_stall = 1'b1;
    InValid = 1'b1; InData = 8'h01; a0 = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt - a0 < 8; k++) step();
    repeat (4) step();
    #2;
    chk("t4_accepted", acc_cnt - a0, 8);
    chk("t4_full_inready", int'(InReady), 0);
    chk("t4_outstanding", int'(Outstanding), 8);
    conv_stall = 1'b0;
    step(); #2;
    chk("t4_reopen_inready", int'(InReady), 1);
    step(); InValid = 1'b0; InData = 8'h00;
    #2 chk("t4_ninth_accepted", acc_cnt - a0, 9);
    drain();

    // 5: mixed sequence with random OutReady
    rnd_out = 1'b1; p0 = pop_cnt;
    send(8'h12); send(8'h00); send(8'h80);
    drain();
    rnd_out = 1'b0;
    chk("t5_beats", pop_cnt - p0, 4);

    // 6: reset while 0xFF is half drained
    OutReady = 1'b1; p0 = pop_cnt;
    send(8'hFF);
    for (int k = 0; k < 30 && pop_cnt - p0 < 4; k++) step();
    #1 RSTN = 1'b0;
    #1;
    chk("t6_rst_outvalid", int'(OutValid), 0);
    chk("t6_rst_readen", int'(ConvReadEnable), 0);
    chk("t6_rst_wen", int'(ConvWriteEnable), 0);
    chk("t6_rst_fields", int'({OutBitPlace, OutLast, OutZero}), 0);
    chk("t6_rst_outstanding", int'(Outstanding), 0);
    repeat (2) step();
    RSTN = 1'b1;
    step(); #2;
    chk("t6_post_outstanding", int'(Outstanding), 0);
    chk("t6_post_outvalid", int'(OutValid), 0);
    step();
    p0 = pop_cnt;
    send(8'h02);
    drain();
    chk("t6_single_beat", pop_cnt - p0, 1);

    // random traffic against the scoreboard
    for (int k = 0; k < 500; k++) begin
      InValid        = 1'($urandom_range(0, 1));
      InData         = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ConvWriteReady = ($urandom_range(0, 3) != 0);
      OutReady       = 1'($urandom_range(0, 1));
      conv_stall     = ($urandom_range(0, 3) == 0);
      step();
    end
    InValid = 1'b0; InData = 8'h00; conv_stall = 1'b0; ConvWriteReady = 1'b1;
    drain();
    step(); #2;
    chk("rand_final_outstanding", int'(Outstanding), 0);
    chk("rand_final_outvalid", int'(OutValid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
